// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between fetch and data ports, data-first with a fetch-starvation guard
module mem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [DATA_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [DATA_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [DATA_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              timeout_err
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int BW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DSERVE, ISERVE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   dstreak_q, dstreak_d;
    logic [BW-1:0]   busy_q, busy_d;
    logic            err_q, err_d;
    logic            dreq, dsrv, isrv, tmo, dhit, ihit, dgo, stay;

    always_comb begin
        dreq     = dREN | dWEN;
        dsrv     = state_q == DSERVE;
        isrv     = state_q == ISERVE;
        tmo      = busy_q == BW'(TIMEOUT);
        dhit     = dsrv & dreq & ram_ready & ~tmo;
        ihit     = isrv & iREN & ram_ready & ~tmo;
        dgo      = dreq & ~(iREN & (dstreak_q == SW'(MAX_DSTREAK)));
        // a withdrawn request, a completion or a watchdog abort all release the RAM
        stay     = ((dsrv & dreq) | (isrv & iREN)) & ~ram_ready & ~tmo;
        iwait    = iREN & ~(isrv & (ram_ready | tmo));
        dwait    = dreq & ~(dsrv & (ram_ready | tmo));
        iload    = ihit ? ramload : '0;
        dload    = (dhit & ~dWEN) ? ramload : '0;
        ramREN   = (dsrv & dREN & ~dWEN) | (isrv & iREN);
        ramWEN   = dsrv & dWEN;
        ramaddr  = dsrv ? daddr : isrv ? iaddr : '0;
        ramstore = dsrv ? dstore : '0;
        state_d  = (state_q == IDLE) ? (dgo ? DSERVE : iREN ? ISERVE : IDLE) : stay ? state_q : IDLE;
        dstreak_d = (~iREN | ihit) ? '0 :
                    (dhit && dstreak_q != SW'(MAX_DSTREAK)) ? dstreak_q + SW'(1) : dstreak_q;
        busy_d   = ~(dsrv | isrv) ? '0 : (~ram_ready & ~tmo) ? busy_q + BW'(1) : busy_q;
        err_d    = err_q | (((dsrv & dreq) | (isrv & iREN)) & tmo);
        timeout_err = err_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            busy_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port RAM arbiter between the instruction-fetch and data-memory requesters of the pipelined core.
- A 3-state FSM owns the RAM for one transaction at a time.
- Data requests have priority. A streak counter guarantees fetch progress under sustained data traffic.
- A busy-cycle watchdog flags a hung RAM.
- Its iwait/dwait outputs feed the pipeline's ihit/dhit stall logic.

Parameters:
- DATA_W, 32, width of addresses and data words.
- MAX_DSTREAK, 4, number of consecutive data grants allowed while a fetch is pending.
- TIMEOUT, 255, number of busy cycles without ram_ready before the watchdog aborts.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request; held until iwait is low.
- iaddr  in  DATA_W  instruction address.
- iwait  out  1  high while an instruction request is pending and not completing.
- iload  out  DATA_W  instruction data; valid only when iREN=1 and iwait=0.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  DATA_W  data address.
- dstore  in  DATA_W  write data.
- dwait  out  1  high while a data request is pending and not completing.
- dload  out  DATA_W  read data; valid only when a data request is asserted and dwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  DATA_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ram_ready  in  1  RAM access completes this cycle; ramload is valid.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Clock and reset: one clock, CLK; RST is asynchronous and active-high.
- States:
  - IDLE: no RAM strobes asserted.
  - DSERVE: RAM driven from the data port.
  - ISERVE: RAM driven from the instruction port.
- IDLE transitions, evaluated each cycle:
  - If dREN|dWEN, and not (iREN and dstreak==MAX_DSTREAK): go to DSERVE.
  - Else if iREN: go to ISERVE.
  - Else: stay in IDLE.
- Strobes are registered: a request seen in IDLE at cycle t drives the RAM strobes from cycle t+1.
- In DSERVE, RAM signals follow the data port each cycle:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN.
  - ramREN=dREN&~dWEN. If dREN and dWEN are both high, the write wins.
- In ISERVE: ramREN=iREN, ramaddr=iaddr, ramWEN=0, ramstore=0.
- Outside DSERVE/ISERVE: all ram* outputs are 0.
- Completion:
  - Occurs on a cycle in xSERVE with ram_ready=1.
  - The owner's wait drops combinationally that same cycle; its load = ramload (dload is 0 on writes).
  - The FSM returns to IDLE on the next edge.
  - Minimum request-to-completion latency is 2 cycles (ram_ready in the first strobe cycle).
- Wait signals: iwait = iREN & ~(ISERVE & ram_ready & ~tmo); dwait = (dREN|dWEN) & ~(DSERVE & ram_ready & ~tmo), then overridden by the timeout rule below.
- There is no back-to-back grant: at least one IDLE cycle separates transactions.
- Owner withdraws its request before ram_ready (abort):
  - Strobes fall combinationally in that cycle.
  - FSM goes to IDLE on the next edge.
  - No completion is signalled and the streak counter is unchanged.
- dstreak counter (width clog2(MAX_DSTREAK+1)):
  - Increments, saturating at MAX_DSTREAK, on each data completion while iREN=1.
  - Clears on any instruction completion.
  - Clears on any cycle with iREN=0.
- Watchdog:
  - busy_cnt clears when entering xSERVE and counts each xSERVE cycle with ram_ready=0.
  - tmo = busy_cnt==TIMEOUT.
  - On tmo: the owner's wait goes low with load=0, timeout_err is set, and the FSM goes to IDLE.
  - timeout_err is cleared only by RST.
- Reset, including mid-transaction: state=IDLE, dstreak=0, busy_cnt=0, timeout_err=0, all ram* outputs 0. Waits equal the raw requests.

Test Plan:
- Reset, then iREN=1, iaddr=0x40, RAM returns ram_ready one cycle after ramREN with ramload=0x8C220004 -> ramREN high at t+1, iwait low and iload=0x8C220004 at t+2, ramREN low at t+3.
- iREN and dREN raised in the same cycle, daddr=0x100 -> data served first, ramaddr=0x100; instruction served after the intervening IDLE cycle.
- iREN held, dWEN re-raised continuously with MAX_DSTREAK=4 -> exactly 4 data writes complete, then ISERVE; dstreak=0 after the fetch completes.
- dREN=dWEN=1, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dload=0 at completion.
- ram_ready held low with TIMEOUT=255 -> dwait low after 255 busy cycles, timeout_err=1 and stays set until RST.
- RST pulsed mid-DSERVE -> ramWEN/ramREN are 0 asynchronously and the FSM is in IDLE; the next request restarts with 2-cycle latency.
